lc3_program_loader: RTL and testbench

- Byte-stream program loader: the writer on the LC-3 memory special-input port (MARSpcIn, MDRSpcIn, ldMARSpcIn).
- Receives a framed program image over a valid/ready byte interface and writes each word into LC-3 memory at consecutive addresses.
- Holds the processor in reset for the whole load; releases it only after the frame checksum verifies.
- Sits beside the LC-3 top: drives Memory's special inputs, and its cpu_hold is ORed into the processor reset.

---
 rtl/lc3_program_loader.sv | 166 ++++++++++++++++
 tb/tb_lc3_program_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3_program_loader.sv
// LC-3 program loader: receives a framed program image over a valid/ready
// byte stream, writes each word into memory through the special-input port,
// and keeps the processor held in reset until the frame checksum verifies.
module lc3_program_loader #(
    parameter bit          HOLD_AT_RESET = 1'b1,
    parameter int unsigned MAX_WORDS     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] MARSpcIn,
    output logic [15:0] MDRSpcIn,
    output logic        ldMARSpcIn,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // ORG_HI | expecting origin high byte
    // ORG_LO | expecting origin low byte
    // CNT_HI | expecting word count high byte
    // CNT_LO | expecting word count low byte
    // DAT_HI | expecting data word high byte
    // DAT_LO | expecting data word low byte
    // WRITE  | one-cycle memory write strobe
    // CHK    | expecting checksum byte
    // DONE   | last load verified, CPU released
    // ERR    | last load failed, CPU held
    typedef enum logic [3:0] {
        IDLE, ORG_HI, ORG_LO, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERR
    } loaderState;

    loaderState state, nextState;

    logic [15:0] origin;
    logic [15:0] count;
    logic [15:0] index;
    logic [7:0]  dataHi;
    logic [7:0]  sum;
    logic [7:0]  sumNext;
    logic [15:0] cntFull;
    logic [16:0] indexInc;
    logic        byteFire;
    logic        cntTooBig;

    assign byteFire  = rx_valid && rx_ready;
    assign sumNext   = sum + rx_data;
    // The low count byte is still on rx_data in CNT_LO, so decide on the full value now.
    assign cntFull   = {count[15:8], rx_data};
    assign cntTooBig = 32'(cntFull) > MAX_WORDS;
    assign indexInc  = {1'b0, index} + 17'd1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state decode and byte-acceptance handshake.
    always_comb begin
        nextState = state;
        rx_ready  = 1'b0;
        case (state)
            IDLE, DONE, ERR: if (start) nextState = ORG_HI;
            ORG_HI: begin
                rx_ready = 1'b1;
                if (byteFire) nextState = ORG_LO;
            end
            ORG_LO: begin
                rx_ready = 1'b1;
                if (byteFire) nextState = CNT_HI;
            end
            CNT_HI: begin
                rx_ready = 1'b1;
                if (byteFire) nextState = CNT_LO;
            end
            CNT_LO: begin
                rx_ready = 1'b1;
                if (byteFire) begin
                    if (cntFull == 16'h0000) nextState = CHK;
                    else if (cntTooBig)      nextState = ERR;
                    else                     nextState = DAT_HI;
                end
            end
            DAT_HI: begin
                rx_ready = 1'b1;
                if (byteFire) nextState = DAT_LO;
            end
            DAT_LO: begin
                rx_ready = 1'b1;
                if (byteFire) nextState = WRITE;
            end
            WRITE: nextState = (indexInc < {1'b0, count}) ? DAT_HI : CHK;
            CHK: begin
                rx_ready = 1'b1;
                if (byteFire) nextState = (sumNext == 8'h00) ? DONE : ERR;
            end
            default: nextState = IDLE;
        endcase
    end

    // Frame datapath, write port and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            origin     <= 16'h0000;
            count      <= 16'h0000;
            index      <= 16'h0000;
            dataHi     <= 8'h00;
            sum        <= 8'h00;
            MARSpcIn   <= 16'h0000;
            MDRSpcIn   <= 16'h0000;
            ldMARSpcIn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= HOLD_AT_RESET;
        end else begin
            // The strobe is high exactly while the FSM sits in WRITE.
            ldMARSpcIn <= (nextState == WRITE);
            if (byteFire) sum <= sumNext;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    done     <= 1'b0;
                    error    <= 1'b0;
                    busy     <= 1'b1;
                    cpu_hold <= 1'b1;
                    sum      <= 8'h00;
                    index    <= 16'h0000;
                end
                ORG_HI: if (byteFire) origin[15:8] <= rx_data;
                ORG_LO: if (byteFire) origin[7:0]  <= rx_data;
                CNT_HI: if (byteFire) count[15:8]  <= rx_data;
                CNT_LO: if (byteFire) begin
                    count[7:0] <= rx_data;
                    if (cntFull != 16'h0000 && cntTooBig) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DAT_HI: if (byteFire) dataHi <= rx_data;
                DAT_LO: if (byteFire) begin
                    MDRSpcIn <= {dataHi, rx_data};
                    MARSpcIn <= origin + index;
                end
                WRITE: index <= index + 16'd1;
                CHK: if (byteFire) begin
                    busy <= 1'b0;
                    if (sumNext == 8'h00) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_program_loader.sv
// Testbench for lc3_program_loader: directed frames, expected memory writes
// queued by the stimulus and checked by an independent strobe monitor.
module tb_lc3_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] MARSpcIn;
    logic [15:0] MDRSpcIn;
    logic        ldMARSpcIn;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] expQ[$];
    logic [31:0] monEntry;
    logic [7:0]  frame[$];
    int          waitLog[0:31];

    lc3_program_loader #(.HOLD_AT_RESET(1'b1), .MAX_WORDS(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .MARSpcIn(MARSpcIn), .MDRSpcIn(MDRSpcIn), .ldMARSpcIn(ldMARSpcIn),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && ldMARSpcIn) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", MARSpcIn, MDRSpcIn);
            end else begin
                monEntry = expQ.pop_front();
                check("write_addr", {16'h0, MARSpcIn}, {16'h0, monEntry[31:16]});
                check("write_data", {16'h0, MDRSpcIn}, {16'h0, monEntry[15:0]});
                check("ready_in_write", {31'h0, rx_ready}, 32'h0);
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input logic doStart, output int waits);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        start    = doStart;
        waits    = 0;
        while (!rx_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL rx_ready_timeout: got rx_ready 0 for 50 cycles expected 1");
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sendFrame(input int startAt);
        for (int i = 0; i < frame.size(); i++)
            sendByte(frame[i], i == startAt, waitLog[i]);
        rx_valid = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input logic d, input logic e,
                               input logic b, input logic h);
        check({tag, "_done"},     {31'h0, done},     {31'h0, d});
        check({tag, "_error"},    {31'h0, error},    {31'h0, e});
        check({tag, "_busy"},     {31'h0, busy},     {31'h0, b});
        check({tag, "_cpu_hold"}, {31'h0, cpu_hold}, {31'h0, h});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        checkStatus("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("reset_ld", {31'h0, ldMARSpcIn}, 32'h0);
        check("reset_mar", {16'h0, MARSpcIn}, 32'h0);
        check("reset_mdr", {16'h0, MDRSpcIn}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle: stray bytes are not accepted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'h5A;
            #1;
            check("idle_rx_ready", {31'h0, rx_ready}, 32'h0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        checkStatus("idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Two-word frame, with a start pulse mid-load that must be ignored.
        pulseStart();
        checkStatus("started", 1'b0, 1'b0, 1'b1, 1'b1);
        check("started_rx_ready", {31'h0, rx_ready}, 32'h1);
        expQ.push_back({16'h3000, 16'h1021});
        expQ.push_back({16'h3001, 16'hF025});
        frame = {8'h30, 8'h00, 8'h00, 8'h02, 8'h10, 8'h21, 8'hF0, 8'h25, 8'h88};
        sendFrame(3);
        check("write_gap_wait", waitLog[6], 32'd1);
        checkStatus("good", 1'b1, 1'b0, 1'b0, 1'b0);
        check("good_queue_drained", expQ.size(), 32'd0);

        // Bad checksum: writes still happen, CPU stays held.
        pulseStart();
        expQ.push_back({16'h3000, 16'h1021});
        expQ.push_back({16'h3001, 16'hF025});
        frame = {8'h30, 8'h00, 8'h00, 8'h02, 8'h10, 8'h21, 8'hF0, 8'h25, 8'h87};
        sendFrame(-1);
        checkStatus("badsum", 1'b0, 1'b1, 1'b0, 1'b1);
        check("badsum_queue_drained", expQ.size(), 32'd0);

        // Correct frame afterwards clears error.
        pulseStart();
        check("restart_error_cleared", {31'h0, error}, 32'h0);
        expQ.push_back({16'h3000, 16'h1021});
        expQ.push_back({16'h3001, 16'hF025});
        frame = {8'h30, 8'h00, 8'h00, 8'h02, 8'h10, 8'h21, 8'hF0, 8'h25, 8'h88};
        sendFrame(-1);
        checkStatus("recover", 1'b1, 1'b0, 1'b0, 1'b0);

        // Address wrap from FFFF to 0000.
        pulseStart();
        check("wrap_hold_reasserted", {31'h0, cpu_hold}, 32'h1);
        expQ.push_back({16'hFFFF, 16'hAAAA});
        expQ.push_back({16'h0000, 16'h5555});
        frame = {8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h02};
        sendFrame(-1);
        checkStatus("wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_queue_drained", expQ.size(), 32'd0);

        // Empty program: straight to the checksum byte.
        pulseStart();
        frame = {8'h40, 8'h00, 8'h00, 8'h00, 8'hC0};
        sendFrame(-1);
        check("count0_chk_wait", waitLog[4], 32'd0);
        checkStatus("count0", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset right after the first data word is accepted: no strobe survives.
        pulseStart();
        frame = {8'h50, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34};
        sendFrame(-1);
        reset = 1'b1;
        #1;
        check("midreset_ld", {31'h0, ldMARSpcIn}, 32'h0);
        check("midreset_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("midreset_mar", {16'h0, MARSpcIn}, 32'h0);
        checkStatus("midreset", 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'h56 + 8'(i);
            #1;
            check("post_reset_rx_ready", {31'h0, rx_ready}, 32'h0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkStatus("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check("final_queue_drained", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
